// File: rtl/p2s_frame_serializer.sv
// ---------------------------------------------------------------------------
// p2s_frame_serializer
//
// Parallel-to-serial framer for the board-to-board battle link. A DATA_W-bit
// word plus an end-of-pass flag are accepted on load && ready and sent on a
// single line, idling high, as:
//   start(0) | DATA_W data bits | end_pass | [parity] | STOP_BITS stop(1)
// Each serial bit is held for BIT_DIV clocks.
//
// Optional feature macro: P2S_SR_PARITY_EN
//   When defined, an even-parity bit (XOR of the data bits and end_pass)
//   follows the end_pass bit.
//
// Ports:
//   ic_clk_ctrl  in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   P_data_in    in   parallel word to send (DATA_W bits)
//   load         in   word valid, accepted when load && ready
//   end_pass     in   end-of-pass marker, captured with P_data_in
//   ready        out  block can accept a word (idle)
//   S_data_out   out  registered serial line, idles high
//   busy         out  frame in progress
//   frame_done   out  one-cycle pulse in the first idle cycle after stop
// ---------------------------------------------------------------------------
module p2s_frame_serializer #(
  parameter int DATA_W    = 8,
  parameter int BIT_DIV   = 1,
  parameter int MSB_FIRST = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              ic_clk_ctrl,
  input  logic              reset,
  input  logic [DATA_W-1:0] P_data_in,
  input  logic              load,
  input  logic              end_pass,
  output logic              ready,
  output logic              S_data_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_LAST,
    S_STOP
`ifdef P2S_SR_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [1:0]        stop_cnt_reg, stop_cnt_next;
  logic [DATA_W-1:0] data_sr_reg, data_sr_next;
  logic              ep_reg, ep_next;
  logic              line_reg, line_next;
  logic              done_reg, done_next;
`ifdef P2S_SR_PARITY_EN
  logic              par_reg, par_next;
`endif

  // Shift register advanced by one position towards the transmit end, so the
  // next bit to send always sits in the same slot (MSB or LSB).
  logic [DATA_W-1:0] data_shifted;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
      if (MSB_FIRST != 0) begin : g_msb
        if (gi == 0) begin : g_fill
          assign data_shifted[gi] = 1'b0;
        end else begin : g_move
          assign data_shifted[gi] = data_sr_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == DATA_W - 1) begin : g_fill
          assign data_shifted[gi] = 1'b0;
        end else begin : g_move
          assign data_shifted[gi] = data_sr_reg[gi+1];
        end
      end
    end
  endgenerate

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  logic bit_tick;
  assign bit_tick = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge ic_clk_ctrl) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= '0;
      data_sr_reg  <= '0;
      ep_reg       <= 1'b0;
      line_reg     <= 1'b1;
      done_reg     <= 1'b0;
`ifdef P2S_SR_PARITY_EN
      par_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      data_sr_reg  <= data_sr_next;
      ep_reg       <= ep_next;
      line_reg     <= line_next;
      done_reg     <= done_next;
`ifdef P2S_SR_PARITY_EN
      par_reg      <= par_next;
`endif
    end
  end

  // line_next is the value the line takes in the state being entered, which
  // keeps S_data_out a plain register with no path from load.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    data_sr_next  = data_sr_reg;
    ep_next       = ep_reg;
    line_next     = line_reg;
    done_next     = 1'b0;
`ifdef P2S_SR_PARITY_EN
    par_next      = par_reg;
`endif
    div_cnt_next  = bit_tick ? '0 : div_cnt_reg + 1'b1;

    case (state_reg)
      S_IDLE: begin
        div_cnt_next = '0;
        line_next    = 1'b1;
        if (load) begin
          data_sr_next = P_data_in;
          ep_next      = end_pass;
`ifdef P2S_SR_PARITY_EN
          par_next     = (^P_data_in) ^ end_pass;
`endif
          state_next   = S_START;
          line_next    = 1'b0;
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_next   = S_DATA;
          bit_cnt_next = '0;
          line_next    = head_bit(data_sr_reg);
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = S_LAST;
            line_next  = ep_reg;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            data_sr_next = data_shifted;
            line_next    = head_bit(data_shifted);
          end
        end
      end
      S_LAST: begin
        if (bit_tick) begin
`ifdef P2S_SR_PARITY_EN
          state_next    = S_PARITY;
          line_next     = par_reg;
`else
          state_next    = S_STOP;
          stop_cnt_next = '0;
          line_next     = 1'b1;
`endif
        end
      end
`ifdef P2S_SR_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          state_next    = S_STOP;
          stop_cnt_next = '0;
          line_next     = 1'b1;
        end
      end
`endif
      S_STOP: begin
        line_next = 1'b1;
        if (bit_tick) begin
          if (stop_cnt_reg == STOP_LAST) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        line_next  = 1'b1;
      end
    endcase
  end

  assign ready      = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign S_data_out = line_reg;
  assign frame_done = done_reg;

endmodule
